// File: rtl/oflow_buffer_read_ctrl_pkg.sv
// rtl/oflow_buffer_read_ctrl_pkg.sv - shared MEM-buffer sizes, read FSM states and slot helpers
package oflow_buffer_read_ctrl_pkg;

  localparam int HIST_DEPTH    = 5;
  localparam int ROWS_PER_SLOT = 16;
  localparam int SLOT_W        = 3;
  localparam int ROW_W         = 4;
  localparam int ADDR_W        = 7;
  localparam int FRAME_NUM_W   = 16;
  localparam int NHIST_W       = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    READ   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } rd_state_e;

  // Previous (older) slot in the circular buffer, 0 wraps to HIST_DEPTH-1.
  function automatic logic [SLOT_W-1:0] slot_prev(input logic [SLOT_W-1:0] s);
    if (s == '0) begin
      return SLOT_W'(HIST_DEPTH - 1);
    end
    return s - 1'b1;
  endfunction

endpackage

// File: rtl/oflow_slot_addr_gen.sv
// rtl/oflow_slot_addr_gen.sv - slot wrap-decrement and buffer row address formation
module oflow_slot_addr_gen
  import oflow_buffer_read_ctrl_pkg::*;
(
  input  logic [SLOT_W-1:0] cur_slot,
  input  logic [SLOT_W-1:0] slot,
  input  logic [SLOT_W-1:0] peek_slot,
  input  logic [ROW_W-1:0]  row,
  output logic [SLOT_W-1:0] first_slot,
  output logic [SLOT_W-1:0] slot_dec,
  output logic [SLOT_W-1:0] peek_dec,
  output logic [ADDR_W-1:0] addr
);

  // Newest history frame sits just behind the slot being written; the
  // address is slot base plus row, all at ADDR_W width.
  always_comb begin
    first_slot = slot_prev(cur_slot);
    slot_dec   = slot_prev(slot);
    peek_dec   = slot_prev(peek_slot);
    addr       = ADDR_W'(slot) * ADDR_W'(ROWS_PER_SLOT) + ADDR_W'(row);
  end

endmodule

// File: rtl/oflow_buffer_read_ctrl.sv
// rtl/oflow_buffer_read_ctrl.sv - history-frame read sequencer feeding the MEM-to-PE interface
module oflow_buffer_read_ctrl
  import oflow_buffer_read_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_N,
  input  logic                   start,
  input  logic [FRAME_NUM_W-1:0] frame_num,
  input  logic [NHIST_W-1:0]     num_of_history_frames,
  input  logic [SLOT_W-1:0]      cur_slot,
  output logic [SLOT_W-1:0]      slot_sel,
  input  logic [ROW_W:0]         rows_in_slot,
  input  logic                   pe_ready,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   data_valid,
  output logic [NHIST_W-1:0]     counter_of_history_frame_to_interface,
  output logic                   last_row,
  output logic                   busy,
  output logic                   done
);

  rd_state_e             state_q, state_d;
  logic [NHIST_W-1:0]    h_q, n_eff_q, pk_h_q, n_eff_new;
  logic [SLOT_W-1:0]     slot_q, pk_slot_q;
  logic [SLOT_W-1:0]     first_slot, slot_dec, peek_dec;
  logic [ROW_W-1:0]      row_q;
  logic [ROW_W:0]        row_cnt_q;
  logic [ADDR_W-1:0]     addr;
  logic                  pk_done_q, pk_any_q, no_more_q, busy_q, done_q;
  logic                  dv_q, last_q;
  logic [NHIST_W-1:0]    hist_q;
  logic [FRAME_NUM_W-1:0] n_lim;
  logic                  final_row, look_hit, look_known, more_frames, last_issue;

  oflow_slot_addr_gen u_addr_gen (
    .cur_slot   (cur_slot),
    .slot       (slot_q),
    .peek_slot  (pk_slot_q),
    .row        (row_q),
    .first_slot (first_slot),
    .slot_dec   (slot_dec),
    .peek_dec   (peek_dec),
    .addr       (addr)
  );

  // Effective depth: never deeper than requested, than frames seen, or than the buffer holds.
  always_comb begin
    n_lim = FRAME_NUM_W'(num_of_history_frames);
    if (frame_num < n_lim) begin
      n_lim = frame_num;
    end
    if (n_lim > FRAME_NUM_W'(HIST_DEPTH - 1)) begin
      n_lim = FRAME_NUM_W'(HIST_DEPTH - 1);
    end
    n_eff_new = NHIST_W'(n_lim);
  end

  // Lookahead over older frames: last_row must mark the final row of the final
  // non-empty frame, so while a frame is read the spare lookup port scans the
  // older slots. The final row of a frame is held back until that scan resolves.
  always_comb begin
    final_row   = ({1'b0, row_q} == (row_cnt_q - 1'b1));
    look_hit    = !pk_done_q && (rows_in_slot != '0);
    look_known  = pk_done_q || (rows_in_slot != '0) || (pk_h_q == n_eff_q);
    more_frames = pk_any_q || look_hit;
  end

  // Next-state and issue logic.
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    slot_sel = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (n_eff_new == '0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        slot_sel = slot_q;
        state_d  = (rows_in_slot == '0) ? NEXT : READ;
      end
      READ: begin
        slot_sel = pk_slot_q;
        if (pe_ready && (!final_row || look_known)) begin
          rd_en = 1'b1;
          if (final_row) begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        state_d = ((h_q == n_eff_q) || no_more_q) ? FINISH : LOAD;
      end
      FINISH: begin
        if (!dv_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_addr    = rd_en ? addr : '0;
    last_issue = rd_en && final_row && !more_frames;
  end

  // Control state: pass parameters, frame/row walk, lookahead scan, busy/done.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q   <= IDLE;
      h_q       <= '0;
      n_eff_q   <= '0;
      slot_q    <= '0;
      row_q     <= '0;
      row_cnt_q <= '0;
      pk_h_q    <= '0;
      pk_slot_q <= '0;
      pk_done_q <= 1'b0;
      pk_any_q  <= 1'b0;
      no_more_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            n_eff_q   <= n_eff_new;
            slot_q    <= first_slot;
            h_q       <= NHIST_W'(1);
            row_q     <= '0;
            no_more_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          row_cnt_q <= rows_in_slot;
          row_q     <= '0;
          pk_h_q    <= h_q + 1'b1;
          pk_slot_q <= slot_dec;
          pk_done_q <= (h_q == n_eff_q);
          pk_any_q  <= 1'b0;
          no_more_q <= 1'b0;
        end
        READ: begin
          if (!pk_done_q) begin
            if (rows_in_slot != '0) begin
              pk_done_q <= 1'b1;
              pk_any_q  <= 1'b1;
            end else if (pk_h_q == n_eff_q) begin
              pk_done_q <= 1'b1;
            end else begin
              pk_h_q    <= pk_h_q + 1'b1;
              pk_slot_q <= peek_dec;
            end
          end
          if (rd_en) begin
            row_q <= row_q + 1'b1;
            if (final_row) begin
              no_more_q <= !more_frames;
            end
          end
        end
        NEXT: begin
          if (!((h_q == n_eff_q) || no_more_q)) begin
            h_q    <= h_q + 1'b1;
            slot_q <= slot_dec;
          end
        end
        FINISH: begin
          if (!dv_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // One-cycle alignment pipe matching the buffer read latency.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      dv_q   <= 1'b0;
      last_q <= 1'b0;
      hist_q <= '0;
    end else begin
      dv_q   <= rd_en;
      last_q <= last_issue;
      if (rd_en) begin
        hist_q <= h_q;
      end
    end
  end

  assign data_valid                            = dv_q;
  assign last_row                              = last_q;
  assign counter_of_history_frame_to_interface = hist_q;
  assign busy                                  = busy_q;
  assign done                                  = done_q;

endmodule

// File: tb/tb_oflow_buffer_read_ctrl.sv
// tb/tb_oflow_buffer_read_ctrl.sv - randomized self-checking bench for oflow_buffer_read_ctrl
module tb_oflow_buffer_read_ctrl;
  import oflow_buffer_read_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset_N;
  logic                   start;
  logic [FRAME_NUM_W-1:0] frame_num;
  logic [NHIST_W-1:0]     num_of_history_frames;
  logic [SLOT_W-1:0]      cur_slot;
  logic [SLOT_W-1:0]      slot_sel;
  logic [ROW_W:0]         rows_in_slot;
  logic                   pe_ready;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   data_valid;
  logic [NHIST_W-1:0]     hist_cnt;
  logic                   last_row;
  logic                   busy;
  logic                   done;

  logic [ROW_W:0] rows_tab [8];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_addr[$];
  int exp_h[$];
  int exp_last[$];

  always #5 clk = ~clk;

  assign rows_in_slot = rows_tab[slot_sel];

  oflow_buffer_read_ctrl dut (
    .clk                                   (clk),
    .reset_N                               (reset_N),
    .start                                 (start),
    .frame_num                             (frame_num),
    .num_of_history_frames                 (num_of_history_frames),
    .cur_slot                              (cur_slot),
    .slot_sel                              (slot_sel),
    .rows_in_slot                          (rows_in_slot),
    .pe_ready                              (pe_ready),
    .rd_en                                 (rd_en),
    .rd_addr                               (rd_addr),
    .data_valid                            (data_valid),
    .counter_of_history_frame_to_interface (hist_cnt),
    .last_row                              (last_row),
    .busy                                  (busy),
    .done                                  (done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int outs_word();
    return int'({rd_en, rd_addr, data_valid, hist_cnt, last_row, busy, done, slot_sel});
  endfunction

  // Reference: list every row the pass should return, newest frame first.
  task automatic build_model(input int fn, input int nh, input int cs, output int ne, output int total);
    ne = nh;
    if (fn < ne) ne = fn;
    if (ne > HIST_DEPTH - 1) ne = HIST_DEPTH - 1;
    exp_addr.delete();
    exp_h.delete();
    exp_last.delete();
    total = 0;
    for (int k = 1; k <= ne; k++) begin
      int s;
      s = (cs - k + HIST_DEPTH) % HIST_DEPTH;
      for (int r = 0; r < int'(rows_tab[s]); r++) begin
        exp_addr.push_back(s * ROWS_PER_SLOT + r);
        exp_h.push_back(k);
        exp_last.push_back(0);
      end
      total += int'(rows_tab[s]);
    end
    if (exp_last.size() > 0) exp_last[exp_last.size() - 1] = 1;
  endtask

  function automatic logic ready_draw(input int stall_pct);
    return int'($urandom_range(99)) >= stall_pct;
  endfunction

  task automatic run_pass(input int fn, input int nh, input int cs, input int stall_pct,
                          input bit dup_start, input string tag);
    int ne, total, cyc, busy_cnt, done_cnt, done_cyc, prev_rd;
    build_model(fn, nh, cs, ne, total);
    @(posedge clk); #1;
    frame_num             = FRAME_NUM_W'(fn);
    num_of_history_frames = NHIST_W'(nh);
    cur_slot              = SLOT_W'(cs);
    start                 = 1'b1;
    pe_ready              = ready_draw(stall_pct);
    cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; prev_rd = 0;
    while (cyc < 400 && done_cnt == 0) begin
      @(negedge clk);
      if (rd_en) begin
        chk({tag, "_rd_without_ready"}, int'(pe_ready), 1);
        if (exp_addr.size() == 0) chk({tag, "_extra_read"}, 1, 0);
        else chk({tag, "_addr"}, int'(rd_addr), exp_addr.pop_front());
      end
      chk({tag, "_valid_delay"}, int'(data_valid), prev_rd);
      if (data_valid) begin
        if (exp_h.size() == 0) chk({tag, "_extra_data"}, 1, 0);
        else begin
          chk({tag, "_hist"}, int'(hist_cnt), exp_h.pop_front());
          chk({tag, "_last"}, int'(last_row), exp_last.pop_front());
        end
      end else begin
        chk({tag, "_last_idle"}, int'(last_row), 0);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_rd = int'(rd_en);
      @(posedge clk); #1;
      start    = dup_start && (cyc == 3);
      pe_ready = ready_draw(stall_pct);
      cyc++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_addr_left"}, exp_addr.size(), 0);
    chk({tag, "_data_left"}, exp_h.size(), 0);
    if (stall_pct == 0) chk({tag, "_busy_bound"}, int'(busy_cnt <= total + 2 * ne + 3), 1);
    if (ne == 0) chk({tag, "_done_latency"}, done_cyc, 2);
    @(negedge clk);
    chk({tag, "_idle_after"}, int'({busy, done, rd_en}), 0);
  endtask

  task automatic set_rows(input int r0, input int r1, input int r2, input int r3, input int r4);
    rows_tab[0] = 5'(r0); rows_tab[1] = 5'(r1); rows_tab[2] = 5'(r2);
    rows_tab[3] = 5'(r3); rows_tab[4] = 5'(r4);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 8; i++) rows_tab[i] = '0;
    reset_N = 1'b0; start = 1'b0; pe_ready = 1'b0;
    frame_num = '0; num_of_history_frames = '0; cur_slot = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_word(), 0);
    reset_N = 1'b1;

    set_rows(2, 2, 2, 2, 2);
    run_pass(10, 3, 2, 0, 1'b0, "basic");
    set_rows(5, 3, 7, 1, 2);
    run_pass(1, 4, 3, 0, 1'b0, "neff1");
    run_pass(0, 4, 3, 0, 1'b0, "frame0");
    set_rows(1, 4, 2, 3, 0);
    run_pass(5, 2, 0, 0, 1'b0, "wrap_skip");
    set_rows(3, 5, 4, 6, 2);
    run_pass(9, 4, 1, 50, 1'b0, "stall");
    run_pass(9, 4, 2, 0, 1'b1, "dup_start");
    set_rows(0, 0, 1, 0, 0);
    run_pass(9, 4, 3, 0, 1'b0, "tail_empty");
    set_rows(0, 0, 0, 0, 0);
    run_pass(9, 4, 3, 0, 1'b0, "all_empty");
    set_rows(3, 16, 2, 1, 4);
    run_pass(7, 1, 2, 0, 1'b0, "full_slot");

    set_rows(4, 4, 4, 4, 4);
    @(posedge clk); #1;
    frame_num = 9; num_of_history_frames = 3; cur_slot = 0; start = 1'b1; pe_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!rd_en && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reset_reached_read", int'(rd_en), 1);
    @(posedge clk); #2;
    reset_N = 1'b0;
    #1;
    chk("reset_mid_outputs", outs_word(), 0);
    @(posedge clk); #1;
    chk("reset_held_outputs", outs_word(), 0);
    reset_N = 1'b1;
    run_pass(9, 3, 0, 0, 1'b0, "after_reset");

    for (int p = 0; p < 20; p++) begin
      for (int s = 0; s < HIST_DEPTH; s++)
        rows_tab[s] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(16, 1));
      run_pass(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(4)),
               ($urandom_range(1) == 0) ? 0 : 40, 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
